// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor; carry-in folded in as an extra prefix column, tag carried alongside.
// Latency: NRANK = 1 + ceil(clog2(WIDTH)/PIPE_EVERY) edges from accept to out_valid (4 for 32/2).
// Backpressure: full ranks stall in place, empty ranks keep filling; in_ready is combinational from out_ready.
module pipelined_prefix_adder #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_vout,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int NRANK  = 1 + (STAGES + PIPE_EVERY - 1) / PIPE_EVERY;

  // Column 0 is the carry-in (pure generate, propagate 0); column j+1 is operand bit j.
  logic [STAGES:1][WIDTH:0] lg;
  logic [STAGES:1][WIDTH:0] lp;

  logic [NRANK-1:0] v;
  logic [NRANK-1:0] adv;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;

  // A rank may load when it or anything downstream of it has a free slot, or the output drains.
  for (genvar r = 0; r < NRANK; r++) begin : g_adv
    assign adv[r] = out_ready | ~(&v[NRANK-1:r]);
  end

  assign in_ready  = adv[0];
  assign out_valid = v[NRANK-1];

  // Valid bits shift forward wherever a rank advances; stalled ranks keep theirs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else     v <= (v & ~adv) | ({v[NRANK-2:0], in_valid} & adv);
  end

  // Ranks 0..NRANK-2 hold partial prefix state, raw propagate bits for the final xor, and the tag.
  for (genvar r = 0; r < NRANK - 1; r++) begin : g_rk
    logic [WIDTH:0]   g, p, g_nx, p_nx;
    logic [WIDTH-1:0] praw, praw_nx;
    logic [TAG_W-1:0] tag, tag_nx;
    logic             load;

    if (r == 0) begin : g_in
      assign g_nx    = {in_a & b_eff, cin_eff};
      assign p_nx    = {in_a ^ b_eff, 1'b0};
      assign praw_nx = in_a ^ b_eff;
      assign tag_nx  = in_tag;
      assign load    = adv[0] & in_valid;
    end else begin : g_mid
      assign g_nx    = lg[r*PIPE_EVERY];
      assign p_nx    = lp[r*PIPE_EVERY];
      assign praw_nx = g_rk[r-1].praw;
      assign tag_nx  = g_rk[r-1].tag;
      assign load    = adv[r] & v[r-1];
    end

    // Capture only when a real operation moves in, so stalled contents stay bit-exact.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        g    <= '0;
        p    <= '0;
        praw <= '0;
        tag  <= '0;
      end else if (load) begin
        g    <= g_nx;
        p    <= p_nx;
        praw <= praw_nx;
        tag  <= tag_nx;
      end
    end
  end

  // Kogge-Stone levels; the first level after each rank boundary reads that rank's registers.
  for (genvar l = 1; l <= STAGES; l++) begin : g_lvl
    logic [WIDTH:0] ig, ip;

    if ((l - 1) % PIPE_EVERY == 0) begin : g_src_reg
      assign ig = g_rk[(l-1)/PIPE_EVERY].g;
      assign ip = g_rk[(l-1)/PIPE_EVERY].p;
    end else begin : g_src_comb
      assign ig = lg[l-1];
      assign ip = lp[l-1];
    end

    for (genvar j = 0; j <= WIDTH; j++) begin : g_col
      if (j >= (1 << (l - 1))) begin : g_merge
        assign lg[l][j] = ig[j] | (ip[j] & ig[j-(1<<(l-1))]);
        assign lp[l][j] = ip[j] & ip[j-(1<<(l-1))];
      end else begin : g_pass
        assign lg[l][j] = ig[j];
        assign lp[l][j] = ip[j];
      end
    end
  end

  // With a power-of-two WIDTH the top column's span stops one short of the carry-in column;
  // folding the carry-in once more closes it and is a no-op for columns already resolved.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_nx;

  assign carry  = lg[STAGES] | (lp[STAGES] & {(WIDTH+1){lg[STAGES][0]}});
  assign sum_nx = g_rk[NRANK-2].praw ^ carry[WIDTH-1:0];

  // Final rank: resolved sum and flags; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_vout <= 1'b0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else if (adv[NRANK-1] && v[NRANK-2]) begin
      out_sum  <= sum_nx;
      out_cout <= carry[WIDTH];
      out_vout <= carry[WIDTH] ^ carry[WIDTH-1];
      out_zero <= ~|sum_nx;
      out_tag  <= g_rk[NRANK-2].tag;
    end
  end

endmodule
